// File: rtl/an_flp_sender.sv
// an_flp_sender: emits Clause 28-style FLP bursts on a differential pair, one 16-bit codeword per burst.
// Latency: busy and the first clock pulse appear the cycle after start is sampled; done follows the last burst by one cycle.
// Backpressure: none; start is ignored while busy and in the done cycle, and an_config is only sampled on acceptance.
module an_flp_sender #(
   parameter int PULSE_CYCLES     = 4,
   parameter int HALF_BIT_CYCLES  = 16,
   parameter int BURST_GAP_CYCLES = 64,
   parameter int NUM_WORDS        = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [16*NUM_WORDS-1:0] an_config,
   output logic                    busy,
   output logic                    done,
   output logic                    an_tx_p,
   output logic                    an_tx_n
);

   localparam int CFG_W  = 16 * NUM_WORDS;
   localparam int POS_W  = $clog2(2 * HALF_BIT_CYCLES);
   localparam int GAP_W  = $clog2(BURST_GAP_CYCLES + 1);
   localparam int WIDX_W = $clog2(NUM_WORDS + 1);

   // Position inside one bit period: clock pulse window, data pulse window, wrap point.
   localparam logic [POS_W-1:0]  POS_PULSE_W   = POS_W'(PULSE_CYCLES);
   localparam logic [POS_W-1:0]  POS_PULSE_END = POS_W'(PULSE_CYCLES - 1);
   localparam logic [POS_W-1:0]  POS_DATA_LO   = POS_W'(HALF_BIT_CYCLES);
   localparam logic [POS_W-1:0]  POS_DATA_HI   = POS_W'(HALF_BIT_CYCLES + PULSE_CYCLES);
   localparam logic [POS_W-1:0]  POS_LAST      = POS_W'(2 * HALF_BIT_CYCLES - 1);
   // Bit period 16 holds only the closing clock pulse.
   localparam logic [4:0]        LAST_BIT      = 5'd16;
   localparam logic [GAP_W-1:0]  GAP_LAST      = GAP_W'(BURST_GAP_CYCLES - 1);
   localparam logic [WIDX_W-1:0] LAST_WIDX     = WIDX_W'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BURST  = 2'd1,
      S_GAP    = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t             r_state;
   logic [POS_W-1:0]   r_pos;
   logic [4:0]         r_bit;
   logic [GAP_W-1:0]   r_gap;
   logic [WIDX_W-1:0]  r_widx;
   logic [15:0]        r_word;
   logic [CFG_W-1:0]   r_cfg;
   logic               r_busy;
   logic               r_done;
   logic               r_tx_p;
   logic               r_tx_n;

   state_t             w_nxt_state;
   logic [POS_W-1:0]   w_nxt_pos;
   logic [4:0]         w_nxt_bit;
   logic [GAP_W-1:0]   w_nxt_gap;
   logic [WIDX_W-1:0]  w_nxt_widx;
   logic [15:0]        w_nxt_word;
   logic [CFG_W-1:0]   w_nxt_cfg;
   logic               w_nxt_tx;

   // Next-state and counter update; r_word is shifted right so bit 0 is always the bit being sent.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_pos   = r_pos;
      w_nxt_bit   = r_bit;
      w_nxt_gap   = r_gap;
      w_nxt_widx  = r_widx;
      w_nxt_word  = r_word;
      w_nxt_cfg   = r_cfg;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_nxt_state = S_BURST;
               w_nxt_pos   = '0;
               w_nxt_bit   = '0;
               w_nxt_widx  = '0;
               w_nxt_word  = an_config[CFG_W-1 -: 16];
               w_nxt_cfg   = an_config << 16;
            end
         end
         S_BURST: begin
            if (r_bit == LAST_BIT && r_pos == POS_PULSE_END) begin
               w_nxt_gap = '0;
               if (r_widx == LAST_WIDX) begin
                  w_nxt_state = S_FINISH;
               end else begin
                  w_nxt_state = S_GAP;
               end
            end else if (r_pos == POS_LAST) begin
               w_nxt_pos  = '0;
               w_nxt_bit  = r_bit + 1'b1;
               w_nxt_word = {1'b0, r_word[15:1]};
            end else begin
               w_nxt_pos = r_pos + 1'b1;
            end
         end
         S_GAP: begin
            if (r_gap == GAP_LAST) begin
               w_nxt_state = S_BURST;
               w_nxt_pos   = '0;
               w_nxt_bit   = '0;
               w_nxt_widx  = r_widx + 1'b1;
               w_nxt_word  = r_cfg[CFG_W-1 -: 16];
               w_nxt_cfg   = r_cfg << 16;
            end else begin
               w_nxt_gap = r_gap + 1'b1;
            end
         end
         S_FINISH: begin
            w_nxt_state = S_IDLE;
         end
         default: begin
            w_nxt_state = S_IDLE;
         end
      endcase
   end

   // Line level for the upcoming cycle: clock pulse at the start of each bit period, data pulse mid-period if the bit is 1.
   always_comb begin
      w_nxt_tx = 1'b0;
      if (w_nxt_state == S_BURST) begin
         if (w_nxt_pos < POS_PULSE_W) begin
            w_nxt_tx = 1'b1;
         end else if (w_nxt_pos >= POS_DATA_LO && w_nxt_pos < POS_DATA_HI && w_nxt_bit != LAST_BIT) begin
            w_nxt_tx = w_nxt_word[0];
         end
      end
   end

   // State, counters and registered outputs; reset aborts any sequence without a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pos   <= '0;
         r_bit   <= '0;
         r_gap   <= '0;
         r_widx  <= '0;
         r_word  <= '0;
         r_cfg   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_tx_p  <= 1'b0;
         r_tx_n  <= 1'b1;
      end else begin
         r_state <= w_nxt_state;
         r_pos   <= w_nxt_pos;
         r_bit   <= w_nxt_bit;
         r_gap   <= w_nxt_gap;
         r_widx  <= w_nxt_widx;
         r_word  <= w_nxt_word;
         r_cfg   <= w_nxt_cfg;
         r_busy  <= (w_nxt_state == S_BURST) || (w_nxt_state == S_GAP);
         r_done  <= (w_nxt_state == S_FINISH);
         r_tx_p  <= w_nxt_tx;
         r_tx_n  <= ~w_nxt_tx;
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign an_tx_p = r_tx_p;
   assign an_tx_n = r_tx_n;

endmodule

// File: tb/tb_an_flp_sender.sv
// tb_an_flp_sender: checks an_flp_sender against a cycle-indexed waveform model of the FLP sequence.
// Latency: the model places pulse cycle 0 one clock after start is sampled in idle.
// Backpressure: not applicable; start is driven as a level from directed stimulus.
module tb_an_flp_sender;

   localparam int P   = 4;
   localparam int H   = 16;
   localparam int G   = 64;
   localparam int NW  = 3;
   localparam int BL  = 32 * H + P;               // active cycles per burst: 516
   localparam int LEN = NW * BL + (NW - 1) * G;   // first pulse to done: 1676

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [16*NW-1:0] an_config = '0;
   logic            busy, done, an_tx_p, an_tx_n;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   an_flp_sender #(
      .PULSE_CYCLES(P), .HALF_BIT_CYCLES(H), .BURST_GAP_CYCLES(G), .NUM_WORDS(NW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .an_config(an_config),
      .busy(busy), .done(done), .an_tx_p(an_tx_p), .an_tx_n(an_tx_n)
   );

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Model: m_cyc is the sequence cycle index (-1 idle); LEN is the done cycle.
   int               m_cyc = -1;
   logic [16*NW-1:0] m_cfg = '0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc <= -1;
      end else if (m_cyc < 0) begin
         if (start) begin
            m_cyc <= 0;
            m_cfg <= an_config;
         end
      end else if (m_cyc >= LEN) begin
         m_cyc <= -1;
      end else begin
         m_cyc <= m_cyc + 1;
      end
   end

   function automatic logic exp_p(input int c, input logic [16*NW-1:0] cfg);
      int w, t, k, r;
      logic [15:0] word;
      if (c < 0 || c >= LEN) return 1'b0;
      w = c / (BL + G);
      t = c % (BL + G);
      if (t >= BL) return 1'b0;
      word = cfg[16*(NW-w)-1 -: 16];
      k = t / (2 * H);
      r = t % (2 * H);
      if (r < P) return 1'b1;
      if (k < 16 && r >= H && r < H + P) return word[k];
      return 1'b0;
   endfunction

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("tx_p", int'(an_tx_p), int'(exp_p(m_cyc, m_cfg)));
         chk("tx_n", int'(an_tx_n), int'(!exp_p(m_cyc, m_cfg)));
         chk("busy", int'(busy), (m_cyc >= 0 && m_cyc < LEN) ? 1 : 0);
         chk("done", int'(done), (m_cyc == LEN) ? 1 : 0);
      end
   end

   // Event recorder for the literal checks.
   int   cyc_g = 0;
   always @(posedge clk) cyc_g <= cyc_g + 1;
   logic prev_p = 1'b0;
   logic prev_busy = 1'b0;
   int   last_rise = 0;
   int   rise_q[$];
   int   done_q[$];
   int   brise_q[$];
   always @(negedge clk) begin
      if (an_tx_p && !prev_p) begin
         rise_q.push_back(cyc_g);
         last_rise <= cyc_g;
      end
      if (!an_tx_p && prev_p) chk("pulse_width", cyc_g - last_rise, P);
      if (busy && !prev_busy) brise_q.push_back(cyc_g);
      if (done) done_q.push_back(cyc_g);
      prev_p    <= an_tx_p;
      prev_busy <= busy;
   end

   function automatic int count_burst(input int w);
      int n = 0;
      int base;
      if (rise_q.size() == 0) return -1;
      base = rise_q[0];
      foreach (rise_q[i]) begin
         if (rise_q[i] - base >= w * (BL + G) && rise_q[i] - base < w * (BL + G) + BL) n++;
      end
      return n;
   endfunction

   function automatic int seq_len();
      if (done_q.size() == 0 || rise_q.size() == 0) return -1;
      return done_q[0] - rise_q[0];
   endfunction

   task automatic clear_q();
      rise_q.delete();
      done_q.delete();
      brise_q.delete();
   endtask

   task automatic start_seq(input logic [16*NW-1:0] cfg);
      @(negedge clk);
      an_config = cfg;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      @(negedge clk);
      while (!done && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s: done not seen within 4000 cycles", name);
      end
      #1;
   endtask

   task automatic wait_busy(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!busy && n < 100);
      if (!busy) begin
         checks++;
         errors++;
         $display("FAIL %s: busy not seen within 100 cycles", name);
      end
   endtask

   initial begin
      int d_exp[7] = '{16, 208, 240, 272, 304, 336, 368};
      int d_q[$];

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_tx_p", int'(an_tx_p), 0);
      chk("rst_tx_n", int'(an_tx_n), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      repeat (3) @(negedge clk);

      // All-zero configuration: clock pulses only.
      clear_q();
      start_seq('0);
      wait_done("t1_done");
      chk("t1_rises", rise_q.size(), 51);
      chk("t1_b0", count_burst(0), 17);
      chk("t1_b1", count_burst(1), 17);
      chk("t1_b2", count_burst(2), 17);
      chk("t1_len", seq_len(), 1676);
      chk("t1_spacing", (rise_q.size() > 1) ? rise_q[1] - rise_q[0] : -1, 32);
      repeat (5) @(negedge clk);

      // Mixed configuration: data pulse positions and counts.
      clear_q();
      start_seq(48'h0FC1_0001_0000);
      wait_done("t2_done");
      chk("t2_b0", count_burst(0), 24);
      chk("t2_b1", count_burst(1), 18);
      chk("t2_b2", count_burst(2), 17);
      chk("t2_len", seq_len(), 1676);
      foreach (rise_q[i]) begin
         if (rise_q[i] - rise_q[0] < BL && (rise_q[i] - rise_q[0]) % 32 == 16) d_q.push_back(rise_q[i] - rise_q[0]);
      end
      chk("t2_ndata", d_q.size(), 7);
      foreach (d_exp[i]) chk("t2_data_t", (i < d_q.size()) ? d_q[i] : -1, d_exp[i]);
      repeat (5) @(negedge clk);

      // Start held high: one sequence at a time, restart in the first idle cycle after done.
      clear_q();
      @(negedge clk);
      an_config = 48'h0000_FFFF_5555;
      start = 1'b1;
      wait_done("t3_done1");
      wait_busy("t3_restart");
      start = 1'b0;
      wait_done("t3_done2");
      chk("t3_ndone", done_q.size(), 2);
      chk("t3_nbusy", brise_q.size(), 2);
      chk("t3_restart_gap", (brise_q.size() > 1 && done_q.size() > 0) ? brise_q[1] - done_q[0] : -1, 2);
      repeat (5) @(negedge clk);

      // Configuration changed after capture.
      clear_q();
      start_seq(48'h1234_ABCD_8001);
      repeat (300) @(negedge clk);
      an_config = 48'hEDCB_5432_7FFE;
      repeat (700) @(negedge clk);
      an_config = 48'hFFFF_FFFF_FFFF;
      wait_done("t4_done");
      chk("t4_b0", count_burst(0), 22);
      chk("t4_b1", count_burst(1), 27);
      chk("t4_b2", count_burst(2), 19);
      chk("t4_rises", rise_q.size(), 68);
      repeat (5) @(negedge clk);

      // Reset at t=200 of burst 1, then a fresh full sequence.
      clear_q();
      start_seq('0);
      if (!busy) wait_busy("t5_busy");
      repeat (BL + G + 200 - 1) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_rst_tx_p", int'(an_tx_p), 0);
      chk("t5_rst_tx_n", int'(an_tx_n), 1);
      chk("t5_rst_busy", int'(busy), 0);
      chk("t5_rst_done", int'(done), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      chk("t5_no_done", done_q.size(), 0);
      clear_q();
      start_seq('0);
      wait_done("t5_done");
      chk("t5_len", seq_len(), 1676);
      chk("t5_rises", rise_q.size(), 51);
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
